fc_ibuf: RTL and testbench

- Input buffer on the receiving side of the fc_func → next-layer write interface.
- Collects the per-address element vectors written by the upstream func unit until one full activation vector (one layer input) is held.
- Then drives the vector into the next layer's crossbar rows bit-serially, LSB plane first, and waits for the CIM layer to finish before accepting the next vector.

---
 rtl/fc_ibuf_if.sv | 33 +++
 rtl/fc_ibuf.sv | 113 +++++++++++
 tb/tb_fc_ibuf.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_ibuf_if.sv
// rtl/fc_ibuf_if.sv - write-vector and crossbar-plane bus of the fc_ibuf input buffer
interface fc_ibuf_if #(
  parameter int DATA_SIZE    = 8,
  parameter int XBAR_SIZE    = 256,
  parameter int IN_TILES     = 16,
  parameter int NUM_CHANNELS = 2
);
  localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
  localparam int NUM_ELEM          = IN_TILES * ELEMENTS_PER_TILE;
  localparam int V_CIM_TILES       = (NUM_ELEM + XBAR_SIZE - 1) / XBAR_SIZE;
  localparam int BIT_W             = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  logic [IN_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data;
  logic                                       i_write_enable;
  logic                                       o_ready;
  logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]      o_xbar_rows;
  logic [BIT_W-1:0]                           o_bit_idx;
  logic                                       o_cim_valid;
  logic                                       i_cim_ready;
  logic                                       o_cim_start;
  logic                                       i_cim_done;
  logic                                       o_overflow;

  modport slave (
    input  i_data, i_write_enable, i_cim_ready, i_cim_done,
    output o_ready, o_xbar_rows, o_bit_idx, o_cim_valid, o_cim_start, o_overflow
  );

  modport master (
    output i_data, i_write_enable, i_cim_ready, i_cim_done,
    input  o_ready, o_xbar_rows, o_bit_idx, o_cim_valid, o_cim_start, o_overflow
  );
endinterface

// File: rtl/fc_ibuf.sv
// rtl/fc_ibuf.sv - collects one activation vector, then streams it bit-serially into the next CIM layer
module fc_ibuf #(
  parameter int DATA_SIZE    = 8,
  parameter int XBAR_SIZE    = 256,
  parameter int IN_TILES     = 16,
  parameter int NUM_CHANNELS = 2
) (
  input  logic      clk,
  input  logic      rst,
  fc_ibuf_if.slave  bus
);
  localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
  localparam int NUM_ADDR          = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS;
  localparam int NUM_ELEM          = IN_TILES * ELEMENTS_PER_TILE;
  localparam int V_CIM_TILES       = (NUM_ELEM + XBAR_SIZE - 1) / XBAR_SIZE;
  localparam int BIT_W             = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int CNT_W             = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT} state_t;

  state_t                                   state;
  logic [CNT_W-1:0]                         wr_cnt;
  logic [BIT_W-1:0]                         bit_idx;
  logic                                     wr_en;
  logic [NUM_ELEM-1:0][DATA_SIZE-1:0]       mem;

  assign wr_en         = bus.i_write_enable && (state == S_FILL);
  assign bus.o_bit_idx = bit_idx;

  // Each element knows statically which write number and channel feed it; padding channels have no home.
  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_elem
    localparam int TILE = e / ELEMENTS_PER_TILE;
    localparam int OFF  = e % ELEMENTS_PER_TILE;
    localparam int ADDR = OFF / NUM_CHANNELS;
    localparam int CHAN = OFF % NUM_CHANNELS;

    logic [DATA_SIZE-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= '0;
      end else if (wr_en && (wr_cnt == CNT_W'(ADDR))) begin
        q <= bus.i_data[TILE][CHAN];
      end
    end

    assign mem[e] = q;
  end

  for (genvar v = 0; v < V_CIM_TILES; v++) begin : g_tile
    for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_row
      localparam int E = v * XBAR_SIZE + r;
      if (E < NUM_ELEM) begin : g_live
        assign bus.o_xbar_rows[v][r] = (state == S_STREAM) && mem[E][bit_idx];
      end else begin : g_pad
        assign bus.o_xbar_rows[v][r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_FILL;
      wr_cnt          <= '0;
      bit_idx         <= '0;
      bus.o_ready     <= 1'b1;
      bus.o_cim_valid <= 1'b0;
      bus.o_cim_start <= 1'b0;
      bus.o_overflow  <= 1'b0;
    end else begin
      bus.o_cim_start <= 1'b0;
      // A write in the same cycle as done is still outside s_fill, so it counts as overflow.
      if (bus.i_write_enable && (state != S_FILL)) begin
        bus.o_overflow <= 1'b1;
      end
      case (state)
        S_FILL: begin
          if (bus.i_write_enable) begin
            if (wr_cnt == CNT_W'(NUM_ADDR - 1)) begin
              wr_cnt          <= '0;
              state           <= S_STREAM;
              bus.o_ready     <= 1'b0;
              bus.o_cim_valid <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (bus.i_cim_ready) begin
            if (bit_idx == BIT_W'(DATA_SIZE - 1)) begin
              bit_idx         <= '0;
              state           <= S_WAIT;
              bus.o_cim_valid <= 1'b0;
              bus.o_cim_start <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.i_cim_done) begin
            state       <= S_FILL;
            bus.o_ready <= 1'b1;
          end
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_ibuf.sv
// tb/tb_fc_ibuf.sv - randomized self-checking bench for fc_ibuf against an element-array model
module tb_fc_ibuf;
  localparam int DS  = 8;
  localparam int XS  = 32;
  localparam int IT  = 2;
  localparam int NC  = 3;
  localparam int EPT = XS / DS;
  localparam int NA  = (EPT + NC - 1) / NC;
  localparam int NE  = IT * EPT;
  localparam int VT  = (NE + XS - 1) / XS;

  typedef logic [IT-1:0][NC-1:0][DS-1:0] vec_t;
  typedef logic [VT-1:0][XS-1:0]         rows_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [DS-1:0] exp_mem [NE];
  rows_t         plane0_seen;

  always #5 clk = ~clk;

  fc_ibuf_if #(.DATA_SIZE(DS), .XBAR_SIZE(XS), .IN_TILES(IT), .NUM_CHANNELS(NC)) bus ();

  fc_ibuf #(.DATA_SIZE(DS), .XBAR_SIZE(XS), .IN_TILES(IT), .NUM_CHANNELS(NC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic rows_t exp_plane(input int b);
    rows_t p;
    p = '0;
    for (int e = 0; e < NE; e++) p[e / XS][e % XS] = exp_mem[e][b];
    return p;
  endfunction

  // Writes NA vectors; element value is its index (rnd=0) or random (rnd=1); padding slots carry 0xFF.
  task automatic do_fill(input bit rnd);
    vec_t d;
    int   off;
    for (int a = 0; a < NA; a++) begin
      for (int i = 0; i < IT; i++) begin
        for (int j = 0; j < NC; j++) begin
          off = a * NC + j;
          if (off >= EPT) begin
            d[i][j] = 8'hFF;
          end else begin
            d[i][j] = rnd ? DS'($urandom_range(0, 254)) : DS'(i * EPT + off);
            exp_mem[i * EPT + off] = d[i][j];
          end
        end
      end
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready_before a=%0d got=%b exp=1", a, bus.o_ready);
      end
      bus.i_data = d;
      bus.i_write_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_write_enable = 1'b0;
      if (a == NA - 1) begin
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_cim_valid !== 1'b1) begin
          errors++;
          $display("FAIL fill_done ready=%b valid=%b exp ready=0 valid=1", bus.o_ready, bus.o_cim_valid);
        end
      end
    end
  endtask

  // Streams all planes; bp=1 applies the 1,0,0,1 ready pattern then random ready.
  task automatic do_stream(input bit bp);
    logic [3:0] pat;
    int acc, cyc;
    logic rdy;
    pat = 4'b1001;
    acc = 0;
    cyc = 0;
    while (acc < DS && cyc < 200) begin
      checks++;
      if (bus.o_cim_valid !== 1'b1 || bus.o_cim_start !== 1'b0) begin
        errors++;
        $display("FAIL stream_valid cyc=%0d valid=%b start=%b exp valid=1 start=0", cyc, bus.o_cim_valid, bus.o_cim_start);
      end
      checks++;
      if (bus.o_bit_idx !== 3'(acc)) begin
        errors++;
        $display("FAIL stream_bit_idx cyc=%0d got=%0d exp=%0d", cyc, bus.o_bit_idx, acc);
      end
      checks++;
      if (bus.o_xbar_rows !== exp_plane(acc)) begin
        errors++;
        $display("FAIL stream_rows plane=%0d got=%h exp=%h", acc, bus.o_xbar_rows, exp_plane(acc));
      end
      if (acc == 0) plane0_seen = bus.o_xbar_rows;
      rdy = bp ? ((cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1))) : 1'b1;
      bus.i_cim_ready = rdy;
      @(posedge clk);
      if (rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    bus.i_cim_ready = 1'b0;
    checks++;
    if (acc != DS) begin
      errors++;
      $display("FAIL stream_timeout accepted=%0d exp=%0d", acc, DS);
    end
    checks++;
    if (!bp && cyc != DS) begin
      errors++;
      $display("FAIL stream_consecutive cycles=%0d exp=%0d", cyc, DS);
    end
    checks++;
    if (bus.o_cim_start !== 1'b1 || bus.o_cim_valid !== 1'b0 || bus.o_xbar_rows !== '0 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL stream_end start=%b valid=%b rows=%h ready=%b exp 1 0 0 0",
               bus.o_cim_start, bus.o_cim_valid, bus.o_xbar_rows, bus.o_ready);
    end
  endtask

  task automatic do_done();
    @(negedge clk);
    checks++;
    if (bus.o_cim_start !== 1'b0 || bus.o_cim_valid !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_bit_idx !== '0) begin
      errors++;
      $display("FAIL wait_state start=%b valid=%b ready=%b idx=%0d exp 0 0 0 0",
               bus.o_cim_start, bus.o_cim_valid, bus.o_ready, bus.o_bit_idx);
    end
    bus.i_cim_done = 1'b1;
    @(negedge clk);
    bus.i_cim_done = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_ready got=%b exp=1", bus.o_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_cim_valid !== 1'b0 || bus.o_overflow !== 1'b0 ||
        bus.o_cim_start !== 1'b0 || bus.o_bit_idx !== '0 || bus.o_xbar_rows !== '0) begin
      errors++;
      $display("FAIL reset ready=%b valid=%b ovf=%b start=%b idx=%0d rows=%h exp 1 0 0 0 0 0",
               bus.o_ready, bus.o_cim_valid, bus.o_overflow, bus.o_cim_start, bus.o_bit_idx, bus.o_xbar_rows);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    do_fill(1'b0);
    do_stream(1'b0);
    checks++;
    if (plane0_seen[0][7:0] !== 8'b10101010 || plane0_seen[0][31:8] !== 24'h0) begin
      errors++;
      $display("FAIL plane0_const got=%h exp=000000aa", plane0_seen);
    end
    do_done();
  endtask

  task automatic test_padding();
    do_fill(1'b1);
    do_stream(1'b0);
    do_done();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      do_fill(1'b1);
      do_stream(1'b1);
      do_done();
    end
  endtask

  task automatic test_overflow();
    do_fill(1'b1);
    do_stream(1'b0);
    @(negedge clk);
    bus.i_data = vec_t'({$urandom, $urandom});
    bus.i_write_enable = 1'b1;
    @(negedge clk);
    bus.i_write_enable = 1'b0;
    checks++;
    if (bus.o_overflow !== 1'b1 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_set ovf=%b ready=%b exp 1 0", bus.o_overflow, bus.o_ready);
    end
    // Done and a stray write together: done wins, the write must not advance the fill count.
    bus.i_write_enable = 1'b1;
    bus.i_cim_done = 1'b1;
    @(negedge clk);
    bus.i_write_enable = 1'b0;
    bus.i_cim_done = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_done_ready got=%b exp=1", bus.o_ready);
    end
    do_fill(1'b1);
    do_stream(1'b0);
    do_done();
    checks++;
    if (bus.o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b exp=1", bus.o_overflow);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_fill(1'b1);
    n = 0;
    while (bus.o_bit_idx !== 3'd3 && n < 20) begin
      bus.i_cim_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    bus.i_cim_ready = 1'b0;
    checks++;
    if (bus.o_bit_idx !== 3'd3) begin
      errors++;
      $display("FAIL areset_reach idx=%0d exp=3", bus.o_bit_idx);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_cim_valid !== 1'b0 || bus.o_bit_idx !== '0 ||
        bus.o_xbar_rows !== '0 || bus.o_overflow !== 1'b0 || bus.o_cim_start !== 1'b0) begin
      errors++;
      $display("FAIL areset ready=%b valid=%b idx=%0d rows=%h ovf=%b start=%b exp 1 0 0 0 0 0",
               bus.o_ready, bus.o_cim_valid, bus.o_bit_idx, bus.o_xbar_rows, bus.o_overflow, bus.o_cim_start);
    end
    for (int e = 0; e < NE; e++) exp_mem[e] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_fill(1'b1);
    do_stream(1'b0);
    do_done();
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_write_enable = 1'b0;
    bus.i_cim_ready = 1'b0;
    bus.i_cim_done = 1'b0;
    for (int e = 0; e < NE; e++) exp_mem[e] = '0;
    test_reset();
    test_fill();
    test_padding();
    test_backpressure();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
